// File: rtl/parking_exit_controller.sv
// Exit gate controller: validates the exit code, drives the gate and LEDs,
// and owns the lot occupancy counter shared with the entrance side.
module parking_exit_controller #(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned CNT_W       = 4,
  parameter logic [3:0]  EXIT_CODE   = 4'b1010,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned OPEN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_exit,
  input  logic             pay_valid,
  input  logic [3:0]       pay_code,
  input  logic             car_passed,
  input  logic             entry_pulse,
  output logic             green_led,
  output logic             red_led,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TmrW = $clog2(OPEN_CYCLES + 1);

  localparam logic [CNT_W-1:0] CapVal      = CNT_W'(CAPACITY);
  localparam logic [TryW-1:0]  MaxTriesVal = TryW'(MAX_TRIES);
  localparam logic [TmrW-1:0]  OpenVal     = TmrW'(OPEN_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPay,
    StWrongPay,
    StOpen,
    StAlarm
  } state_e;

  state_e           state_q, state_d;
  logic [TryW-1:0]  tries_q, tries_d;
  logic [TryW-1:0]  tries_inc;
  logic [TmrW-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic             gate_q, gate_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             exit_dec;

  assign tries_inc = tries_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    timer_d  = timer_q;
    exit_dec = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A car at the exit with an empty lot cannot be real.
        if (sensor_exit && (occ_q != '0)) begin
          state_d = StWaitPay;
        end
      end
      StWaitPay: begin
        if (!sensor_exit) begin
          state_d = StIdle;
          tries_d = '0;
        end else if (pay_valid) begin
          if (pay_code == EXIT_CODE) begin
            state_d = StOpen;
            tries_d = '0;
            timer_d = OpenVal;
          end else begin
            tries_d = tries_inc;
            state_d = (tries_inc == MaxTriesVal) ? StAlarm : StWrongPay;
          end
        end
      end
      StWrongPay: begin
        state_d = StWaitPay;
      end
      StOpen: begin
        if (car_passed) begin
          state_d  = StIdle;
          timer_d  = '0;
          exit_dec = (occ_q != '0);
        end else if (timer_q <= TmrW'(1)) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StAlarm: begin
        if (!sensor_exit) begin
          state_d = StIdle;
          tries_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Simultaneous entry and exit cancel out, even when the lot is full.
  always_comb begin
    occ_d = occ_q;
    if (entry_pulse && !exit_dec) begin
      if (occ_q < CapVal) begin
        occ_d = occ_q + 1'b1;
      end
    end else if (!entry_pulse && exit_dec) begin
      occ_d = occ_q - 1'b1;
    end
    full_d  = (occ_d == CapVal);
    empty_d = (occ_d == '0);
  end

  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    gate_d  = 1'b0;
    unique case (state_d)
      StWaitPay, StWrongPay: begin
        red_d = 1'b1;
      end
      StOpen: begin
        green_d = 1'b1;
        gate_d  = 1'b1;
      end
      StAlarm: begin
        // Blink starts lit on the first alarm cycle.
        red_d = (state_q == StAlarm) ? ~red_q : 1'b1;
      end
      default: begin
        green_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tries_q <= '0;
      timer_q <= '0;
      occ_q   <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      gate_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      occ_q   <= occ_d;
      green_q <= green_d;
      red_q   <= red_d;
      gate_q  <= gate_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign green_led = green_q;
  assign red_led   = red_q;
  assign gate_open = gate_q;
  assign occupancy = occ_q;
  assign lot_full  = full_q;
  assign lot_empty = empty_q;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Bench for parking_exit_controller: directed scenarios with an event-level
// model checked every cycle, plus literal expectations at key points.
module tb_parking_exit_controller;

  localparam int Capacity   = 8;
  localparam int MaxTries   = 3;
  localparam int OpenCycles = 16;
  localparam logic [3:0] Code = 4'b1010;

  logic       clk;
  logic       rst;
  logic       sensor_exit;
  logic       pay_valid;
  logic [3:0] pay_code;
  logic       car_passed;
  logic       entry_pulse;
  logic       green_led;
  logic       red_led;
  logic       gate_open;
  logic [3:0] occupancy;
  logic       lot_full;
  logic       lot_empty;

  int errors = 0;
  int checks = 0;

  parking_exit_controller #(
    .CAPACITY   (Capacity),
    .CNT_W      (4),
    .EXIT_CODE  (Code),
    .MAX_TRIES  (MaxTries),
    .OPEN_CYCLES(OpenCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_exit(sensor_exit),
    .pay_valid  (pay_valid),
    .pay_code   (pay_code),
    .car_passed (car_passed),
    .entry_pulse(entry_pulse),
    .green_led  (green_led),
    .red_led    (red_led),
    .gate_open  (gate_open),
    .occupancy  (occupancy),
    .lot_full   (lot_full),
    .lot_empty  (lot_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: what a car at the exit is doing, not gate states.
  int m_occ, m_tries, m_open_left, m_dec;
  bit m_waiting, m_penalty, m_alarm, m_blink;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_occ = 0; m_tries = 0; m_open_left = 0;
      m_waiting = 0; m_penalty = 0; m_alarm = 0; m_blink = 0;
    end else begin
      m_dec = 0;
      if (m_open_left > 0) begin
        if (car_passed) begin
          m_open_left = 0;
          m_dec = (m_occ > 0) ? 1 : 0;
        end else begin
          m_open_left--;
        end
      end else if (m_alarm) begin
        if (!sensor_exit) begin
          m_alarm = 0; m_tries = 0; m_blink = 0;
        end else begin
          m_blink = !m_blink;
        end
      end else if (m_penalty) begin
        m_penalty = 0; m_waiting = 1;
      end else if (m_waiting) begin
        if (!sensor_exit) begin
          m_waiting = 0; m_tries = 0;
        end else if (pay_valid) begin
          m_waiting = 0;
          if (pay_code == Code) begin
            m_tries = 0; m_open_left = OpenCycles;
          end else begin
            m_tries++;
            if (m_tries == MaxTries) begin
              m_alarm = 1; m_blink = 1;
            end else begin
              m_penalty = 1;
            end
          end
        end
      end else if (sensor_exit && m_occ != 0) begin
        m_waiting = 1;
      end
      if (entry_pulse && m_dec == 0) m_occ = (m_occ < Capacity) ? m_occ + 1 : m_occ;
      else if (!entry_pulse && m_dec == 1) m_occ = m_occ - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_green", green_led, (m_open_left > 0) ? 1 : 0);
      check("model_gate", gate_open, (m_open_left > 0) ? 1 : 0);
      check("model_red", red_led, (m_waiting || m_penalty || (m_alarm && m_blink)) ? 1 : 0);
      check("model_occ", occupancy, m_occ);
      check("model_full", lot_full, (m_occ == Capacity) ? 1 : 0);
      check("model_empty", lot_empty, (m_occ == 0) ? 1 : 0);
    end
  end

  // Apply one cycle of inputs; returns at the following negedge.
  task automatic cyc(input logic se, input logic pv, input logic [3:0] pc,
                     input logic cp, input logic ep);
    sensor_exit = se; pay_valid = pv; pay_code = pc; car_passed = cp; entry_pulse = ep;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    sensor_exit = 1'b0; pay_valid = 1'b0; pay_code = 4'h0;
    car_passed = 1'b0; entry_pulse = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_green", green_led, 0);
    check("rst_red", red_led, 0);
    check("rst_gate", gate_open, 0);
    check("rst_occ", occupancy, 0);
    check("rst_full", lot_full, 0);
    check("rst_empty", lot_empty, 1);
    @(negedge clk);
    rst = 1'b0;

    // Normal exit
    repeat (3) cyc(0, 0, 4'h0, 0, 1);
    check("t1_occ3", occupancy, 3);
    check("t1_not_empty", lot_empty, 0);
    cyc(1, 0, 4'h0, 0, 0);
    check("t1_wait_red", red_led, 1);
    cyc(1, 1, 4'b1010, 0, 0);
    check("t1_gate", gate_open, 1);
    check("t1_green", green_led, 1);
    cyc(1, 0, 4'h0, 1, 0);
    check("t1_occ2", occupancy, 2);
    check("t1_idle_red", red_led, 0);
    check("t1_idle_gate", gate_open, 0);

    // Wrong codes lead to alarm
    cyc(1, 0, 4'h0, 0, 0);
    cyc(1, 1, 4'b0000, 0, 0);
    check("t2_wrong1_red", red_led, 1);
    cyc(1, 1, 4'b1010, 0, 0);
    check("t2_ignored_in_wrong", gate_open, 0);
    cyc(1, 1, 4'b1111, 0, 0);
    cyc(1, 0, 4'h0, 0, 0);
    cyc(1, 1, 4'b0001, 0, 0);
    check("t2_alarm_red1", red_led, 1);
    cyc(1, 0, 4'h0, 0, 0);
    check("t2_alarm_red0", red_led, 0);
    cyc(1, 0, 4'h0, 0, 0);
    check("t2_alarm_red1b", red_led, 1);
    check("t2_alarm_gate", gate_open, 0);
    cyc(0, 0, 4'h0, 0, 0);
    check("t2_idle_red", red_led, 0);
    cyc(1, 0, 4'h0, 0, 0);
    cyc(1, 1, 4'b1010, 0, 0);
    check("t2_retry_gate", gate_open, 1);
    cyc(1, 0, 4'h0, 1, 0);
    check("t2_occ1", occupancy, 1);

    // Gate timeout
    cyc(1, 0, 4'h0, 0, 0);
    cyc(1, 1, 4'b1010, 0, 0);
    check("t3_open", gate_open, 1);
    for (int i = 0; i < OpenCycles - 1; i++) begin
      cyc(0, 0, 4'h0, 0, 0);
      check("t3_still_open", gate_open, 1);
    end
    cyc(0, 0, 4'h0, 0, 0);
    check("t3_closed", gate_open, 0);
    check("t3_occ_kept", occupancy, 1);

    // Saturation and simultaneous entry/exit
    repeat (9) cyc(0, 0, 4'h0, 0, 1);
    check("t4_occ8", occupancy, 8);
    check("t4_full", lot_full, 1);
    cyc(1, 0, 4'h0, 0, 0);
    cyc(1, 1, 4'b1010, 0, 0);
    cyc(1, 0, 4'h0, 1, 1);
    check("t4_occ_net0", occupancy, 8);
    check("t4_full_kept", lot_full, 1);
    check("t4_gate_closed", gate_open, 0);
    cyc(0, 0, 4'h0, 0, 0);

    // Phantom car, then back-away priority over payment
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (3) cyc(1, 0, 4'h0, 0, 0);
    check("t5_phantom_red", red_led, 0);
    cyc(1, 0, 4'h0, 0, 1);
    cyc(1, 0, 4'h0, 0, 0);
    check("t5_wait_red", red_led, 1);
    cyc(0, 1, 4'b1010, 0, 0);
    check("t5_backaway_gate", gate_open, 0);
    check("t5_backaway_red", red_led, 0);
    cyc(0, 0, 4'h0, 0, 0);
    check("t5_never_open", gate_open, 0);

    // Asynchronous reset while open
    cyc(1, 0, 4'h0, 0, 0);
    cyc(1, 1, 4'b1010, 0, 0);
    check("t6_open", gate_open, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_gate", gate_open, 0);
    check("t6_async_green", green_led, 0);
    check("t6_async_occ", occupancy, 0);
    check("t6_async_empty", lot_empty, 1);
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (2) cyc(0, 0, 4'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
